axis_pkt_gen: RTL and testbench

Synthesizable AXI4-Stream packet transmitter for simulation test harnesses and loopback designs. It drives a programmable number of fixed-length packets with a deterministic data pattern, so the stream slave BFM's collect path can check each beat. It supports back-to-back transfers and honours dready backpressure on every beat.

---
 rtl/axis_pkt_gen.sv | 192 +++++++++++++++++++
 tb/tb_axis_pkt_gen.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pkt_gen.sv
// AXI4-Stream packet generator: fixed-length packets carrying word = seed + global beat index.
// Define AXIS_PKT_GEN_GAP_EN to build the inter-packet idle gap (GAP state, gap_cycles counter).
module axis_pkt_gen #(
    parameter int unsigned DWIDTH  = 512,
    parameter int unsigned KWIDTH  = 64,
    parameter int unsigned UWIDTH  = 32,
    parameter int unsigned MAX_LEN = 256,
    parameter int unsigned LW      = $clog2(MAX_LEN + 1)
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              start,
    input  logic              stop,
    input  logic [LW-1:0]     pkt_len,
    input  logic [15:0]       pkt_num,
    input  logic [31:0]       seed,
    input  logic [KWIDTH-1:0] last_keep,
    input  logic [UWIDTH-1:0] user_in,
    input  logic [7:0]        gap_cycles,
    output logic [DWIDTH-1:0] ddata,
    output logic [KWIDTH-1:0] dkeep,
    output logic [UWIDTH-1:0] duser,
    output logic              dlast,
    output logic              dvalid,
    input  logic              dready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       pkt_cnt
);

    localparam int unsigned NW = DWIDTH / 32;

`ifdef AXIS_PKT_GEN_GAP_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2, FINISH = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, FINISH = 2'd3} state_t;
`endif

    state_t            state;
    logic [LW-1:0]     len_q;
    logic [15:0]       num_q;
    logic [31:0]       seed_q;
    logic [KWIDTH-1:0] keep_q;
    logic [UWIDTH-1:0] user_q;
    logic [31:0]       beat_idx;
    logic [LW-1:0]     beat_pos;
    logic              stop_pend;

    logic [31:0] word;
    logic        beat_last;
    logic        pkt_end;
    logic        last_pkt;
    logic        stop_any;
    logic        gap_go;
    logic        leave_send;
    logic        load_beat;

`ifdef AXIS_PKT_GEN_GAP_EN
    logic [7:0] gap_q;
    logic [7:0] gap_cnt;
    assign gap_go = (gap_q != 8'd0);
`else
    logic unused_gap;
    assign unused_gap = ^gap_cycles;
    assign gap_go     = 1'b0;
`endif

    // beat_idx/beat_pos always describe the next beat to be placed on the bus
    assign word       = seed_q + beat_idx;
    assign beat_last  = (beat_pos == len_q - LW'(1));
    assign pkt_end    = dvalid & dready & dlast;
    assign last_pkt   = ((pkt_cnt + 16'd1) == num_q);
    assign stop_any   = stop_pend | stop;
    assign leave_send = last_pkt | stop_any | gap_go;

    always_comb begin
        load_beat = 1'b0;
        case (state)
            SEND:    load_beat = (!dvalid || dready) && !(pkt_end && leave_send);
`ifdef AXIS_PKT_GEN_GAP_EN
            // last gap cycle presents the next beat so the idle run is exactly gap_cycles long
            GAP:     load_beat = (gap_cnt == 8'd1) && !stop_any;
`endif
            default: load_beat = 1'b0;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= IDLE;
            len_q     <= '0;
            num_q     <= '0;
            seed_q    <= '0;
            keep_q    <= '0;
            user_q    <= '0;
            beat_idx  <= '0;
            beat_pos  <= '0;
            stop_pend <= 1'b0;
            ddata     <= '0;
            dkeep     <= '0;
            duser     <= '0;
            dlast     <= 1'b0;
            dvalid    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            pkt_cnt   <= '0;
`ifdef AXIS_PKT_GEN_GAP_EN
            gap_q     <= '0;
            gap_cnt   <= '0;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (pkt_len == '0 || pkt_len > LW'(MAX_LEN)) begin
                            err <= 1'b1;
                        end else if (pkt_num == 16'd0) begin
                            state <= FINISH;
                            busy  <= 1'b1;
                        end else begin
                            len_q     <= pkt_len;
                            num_q     <= pkt_num;
                            seed_q    <= seed;
                            keep_q    <= last_keep;
                            user_q    <= user_in;
`ifdef AXIS_PKT_GEN_GAP_EN
                            gap_q     <= gap_cycles;
`endif
                            pkt_cnt   <= '0;
                            beat_idx  <= '0;
                            beat_pos  <= '0;
                            stop_pend <= 1'b0;
                            state     <= SEND;
                            busy      <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (stop) stop_pend <= 1'b1;
                    if (pkt_end) begin
                        pkt_cnt <= pkt_cnt + 16'd1;
                        if (last_pkt || stop_any) begin
                            state  <= FINISH;
                            dvalid <= 1'b0;
                            dlast  <= 1'b0;
                        end
`ifdef AXIS_PKT_GEN_GAP_EN
                        else if (gap_go) begin
                            state   <= GAP;
                            gap_cnt <= gap_q;
                            dvalid  <= 1'b0;
                            dlast   <= 1'b0;
                        end
`endif
                    end
                end
`ifdef AXIS_PKT_GEN_GAP_EN
                GAP: begin
                    if (stop) stop_pend <= 1'b1;
                    if (gap_cnt == 8'd1) begin
                        state <= stop_any ? FINISH : SEND;
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end
`endif
                FINISH: begin
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    stop_pend <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (load_beat) begin
                ddata    <= {NW{word}};
                dkeep    <= beat_last ? keep_q : '1;
                duser    <= beat_last ? user_q : '0;
                dlast    <= beat_last;
                dvalid   <= 1'b1;
                beat_idx <= beat_idx + 32'd1;
                beat_pos <= beat_last ? '0 : beat_pos + LW'(1);
            end
        end
    end

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Directed/randomized bench for axis_pkt_gen; expected beats come from a per-run arithmetic model.
module tb_axis_pkt_gen;

    localparam int unsigned DW = 64;
    localparam int unsigned KW = 8;
    localparam int unsigned UW = 8;
    localparam int unsigned ML = 16;
    localparam int unsigned LW = $clog2(ML + 1);

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          dready = 1'b0;
    logic [LW-1:0] pkt_len = '0;
    logic [15:0]   pkt_num = '0;
    logic [31:0]   seed = '0;
    logic [KW-1:0] last_keep = '0;
    logic [UW-1:0] user_in = '0;
    logic [7:0]    gap_cycles = '0;
    logic [DW-1:0] ddata;
    logic [KW-1:0] dkeep;
    logic [UW-1:0] duser;
    logic          dlast;
    logic          dvalid;
    logic          busy;
    logic          done;
    logic          err;
    logic [15:0]   pkt_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 aclk = ~aclk;

    axis_pkt_gen #(
        .DWIDTH (DW),
        .KWIDTH (KW),
        .UWIDTH (UW),
        .MAX_LEN(ML)
    ) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .start     (start),
        .stop      (stop),
        .pkt_len   (pkt_len),
        .pkt_num   (pkt_num),
        .seed      (seed),
        .last_keep (last_keep),
        .user_in   (user_in),
        .gap_cycles(gap_cycles),
        .ddata     (ddata),
        .dkeep     (dkeep),
        .duser     (duser),
        .dlast     (dlast),
        .dvalid    (dvalid),
        .dready    (dready),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .pkt_cnt   (pkt_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // mode 0: dready=1, mode 1: dready 1,0,0,1 repeating, mode 2: random
    task automatic run_pkts(input int len, input int num, input logic [31:0] sd,
                            input logic [KW-1:0] kp, input logic [UW-1:0] us,
                            input logic [7:0] gap, input int stop_beat, input int mode);
        int          pkts, total, exp_idx, cyc, first_cyc, idle, exp_gap;
        bit          counting, stop_sent, fin, is_last;
        logic        pv, pr, pl;
        logic [63:0] pd;
        logic [31:0] w;

        pkts = num;
        if (stop_beat >= 0 && (stop_beat / len + 1) < num) pkts = stop_beat / len + 1;
        total = pkts * len;
`ifdef AXIS_PKT_GEN_GAP_EN
        exp_gap = int'(gap);
`else
        exp_gap = 0;
`endif
        pkt_len    = LW'(len);
        pkt_num    = 16'(num);
        seed       = sd;
        last_keep  = kp;
        user_in    = us;
        gap_cycles = gap;
        pulse_start();
        chk("start_busy", busy, 1);
        chk("start_novalid", dvalid, 0);

        exp_idx = 0; cyc = 0; first_cyc = -1; idle = 0;
        counting = 0; stop_sent = 0; fin = 0;
        pv = 0; pr = 0; pl = 0; pd = '0;
        while (!fin && cyc < 3000) begin
            case (mode)
                0:       dready = 1'b1;
                1:       dready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: dready = 1'($urandom_range(0, 1));
            endcase
            chk("no_early_done", done, 0);
            if (pv && !pr) begin
                chk("hold_valid", dvalid, 1);
                chk("hold_data", ddata, pd);
                chk("hold_last", dlast, pl);
            end
            if (dvalid && first_cyc < 0) begin
                first_cyc = cyc;
                chk("first_beat_latency", cyc, 1);
            end
            if (counting && dvalid) begin
                chk("gap_len", idle, exp_gap);
                counting = 0;
            end else if (counting) begin
                idle++;
            end
            if (stop_beat >= 0 && !stop_sent && dvalid && exp_idx == stop_beat) begin
                stop = 1'b1;
                stop_sent = 1;
            end
            if (dvalid && dready) begin
                w = sd + 32'(exp_idx);
                is_last = ((exp_idx % len) == len - 1);
                chk("beat_data", ddata, {w, w});
                chk("beat_last", dlast, is_last);
                chk("beat_keep", dkeep, is_last ? kp : 8'hFF);
                chk("beat_user", duser, is_last ? us : 8'h00);
                exp_idx++;
                if (exp_idx == total) fin = 1;
                else if (is_last) begin counting = 1; idle = 0; end
            end
            pv = dvalid; pr = dready; pd = ddata; pl = dlast;
            tick();
            stop = 1'b0;
            cyc++;
        end
        chk("beats_total", exp_idx, total);
        chk("end_novalid", dvalid, 0);
        chk("end_done_not_yet", done, 0);
        chk("end_busy_finish", busy, 1);
        tick();
        chk("done_pulse", done, 1);
        chk("end_idle", busy, 0);
        chk("pkt_cnt", pkt_cnt, pkts);
        tick();
        chk("done_once", done, 0);
        repeat (4) tick();
        chk("no_more_beats", dvalid, 0);
    endtask

    initial begin
        dready = 1'b1;
        repeat (3) tick();
        chk("rst_dvalid", dvalid, 0);
        chk("rst_ddata", ddata, 0);
        chk("rst_dkeep", dkeep, 0);
        chk("rst_duser", duser, 0);
        chk("rst_dlast", dlast, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_pkt_cnt", pkt_cnt, 0);
        aresetn = 1'b1;
        tick();

        run_pkts(4, 2, 32'h10, 8'h0F, 8'hA5, 8'd0, -1, 0);
        run_pkts(4, 2, 32'h10, 8'h0F, 8'hA5, 8'd0, -1, 1);

        // illegal lengths are rejected with a single err pulse
        pkt_len = '0; pkt_num = 16'd2;
        pulse_start();
        chk("len0_err", err, 1);
        chk("len0_busy", busy, 0);
        tick();
        chk("len0_err_once", err, 0);
        chk("len0_idle", busy, 0);
        pkt_len = LW'(ML + 1);
        pulse_start();
        chk("lenmax_err", err, 1);
        chk("lenmax_novalid", dvalid, 0);
        tick();
        chk("lenmax_err_once", err, 0);

        // zero packets: straight to FINISH, no beats
        pkt_len = LW'(4); pkt_num = 16'd0;
        pulse_start();
        chk("num0_busy", busy, 1);
        chk("num0_novalid", dvalid, 0);
        tick();
        chk("num0_done", done, 1);
        chk("num0_novalid2", dvalid, 0);
        chk("num0_idle", busy, 0);
        tick();
        chk("num0_done_once", done, 0);

        // stop during beat 1 of packet 2 (global beat 4)
        run_pkts(3, 5, $urandom, 8'h3C, 8'h5A, 8'd0, 4, 0);
        run_pkts(2, 2, $urandom, 8'h01, 8'h77, 8'd3, -1, 0);
        run_pkts(1, 4, $urandom, 8'h81, 8'h12, 8'd0, -1, 2);
        run_pkts(16, 2, 32'hFFFF_FFF8, 8'hF0, 8'h34, 8'd1, -1, 2);
        for (int i = 0; i < 6; i++) begin
            run_pkts(int'($urandom_range(1, ML)), int'($urandom_range(1, 4)), $urandom,
                     8'($urandom), 8'($urandom), 8'($urandom_range(0, 3)), -1, 2);
        end

        // asynchronous reset mid-packet
        pkt_len = LW'(8); pkt_num = 16'd3; seed = $urandom; dready = 1'b1;
        pulse_start();
        repeat (3) tick();
        chk("pre_rst_valid", dvalid, 1);
        #2 aresetn = 1'b0;
        #1;
        chk("async_rst_valid", dvalid, 0);
        chk("async_rst_busy", busy, 0);
        tick();
        aresetn = 1'b1;
        repeat (5) tick();
        chk("no_resume_valid", dvalid, 0);
        chk("no_resume_busy", busy, 0);
        run_pkts(3, 2, 32'h0, 8'h07, 8'h99, 8'd0, -1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
